// File: rtl/flag_pkg.sv
// Shared encodings and constants for the N/V/Z flag generator.
// FLG_Z names the Z-only update class, so the Z bit index is FLG_Z_BIT.
package flag_pkg;

  localparam int DATA_W = 16;

  localparam int FLG_N     = 2;
  localparam int FLG_V     = 1;
  localparam int FLG_Z_BIT = 0;

  typedef enum logic [1:0] {
    FLG_NONE = 2'b00,
    FLG_Z    = 2'b01,
    FLG_NVZ  = 2'b10
  } opClass_e;

  localparam logic [2:0] MASK_Z   = 3'b001;
  localparam logic [2:0] MASK_NVZ = 3'b111;

endpackage

// File: rtl/flag_calc.sv
// Combinational N/V/Z computation from the EX-stage ALU operands and result.
module flag_calc
  import flag_pkg::*;
(
  input  logic              alu_sub_i,
  input  logic [DATA_W-1:0] alu_a_i,
  input  logic [DATA_W-1:0] alu_b_i,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [2:0]        nvz_o
);

  logic aSign;
  logic bSign;
  logic rSign;
  logic unusedLowBits;

  assign aSign = alu_a_i[DATA_W-1];
  assign bSign = alu_b_i[DATA_W-1];
  assign rSign = alu_result_i[DATA_W-1];

  // Only the operand sign bits matter for overflow.
  assign unusedLowBits = ^{alu_a_i[DATA_W-2:0], alu_b_i[DATA_W-2:0]};

  // Operands are pre-inversion, so subtract overflows when the signs differ.
  always_comb begin
    nvz_o            = 3'b000;
    nvz_o[FLG_N]     = rSign;
    nvz_o[FLG_Z_BIT] = (alu_result_i == '0);
    if (alu_sub_i) begin
      nvz_o[FLG_V] = (aSign != bSign) & (rSign != aSign);
    end else begin
      nvz_o[FLG_V] = (aSign == bSign) & (rSign != aSign);
    end
  end

endmodule

// File: rtl/flag_gen.sv
// Condition-flag generator: one pending stage followed by the committed register.
// Define FLAG_BYPASS_EN to forward pending flags onto NVZflag and tie flag_busy low.
module flag_gen
  import flag_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        op_class,
  input  logic              alu_sub,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [2:0]        NVZflag,
  output logic              flag_busy
);

  logic [2:0] calcFlags;
  logic [2:0] captureMask;
  logic       capture;

  logic [2:0] flags_q,     flags_d;
  logic [2:0] pendFlags_q, pendFlags_d;
  logic [2:0] pendMask_q,  pendMask_d;
  logic       pendValid_q, pendValid_d;
  logic [2:0] mergedFlags;

  flag_calc u_flag_calc (
    .alu_sub_i    (alu_sub),
    .alu_a_i      (alu_a),
    .alu_b_i      (alu_b),
    .alu_result_i (alu_result),
    .nvz_o        (calcFlags)
  );

  // Reserved class 11 behaves like "none" and never captures.
  always_comb begin
    captureMask = 3'b000;
    case (op_class)
      FLG_Z:   captureMask = MASK_Z;
      FLG_NVZ: captureMask = MASK_NVZ;
      default: captureMask = 3'b000;
    endcase
  end

  assign capture     = ex_valid & ~stall & ~flush & (captureMask != 3'b000);
  assign mergedFlags = (flags_q & ~pendMask_q) | (pendFlags_q & pendMask_q);

  // A pending update always commits; a same-edge capture refills the stage.
  always_comb begin
    flags_d     = pendValid_q ? mergedFlags : flags_q;
    pendValid_d = 1'b0;
    pendFlags_d = 3'b000;
    pendMask_d  = 3'b000;
    if (capture) begin
      pendValid_d = 1'b1;
      pendFlags_d = calcFlags;
      pendMask_d  = captureMask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= 3'b000;
      pendFlags_q <= 3'b000;
      pendMask_q  <= 3'b000;
      pendValid_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      pendFlags_q <= pendFlags_d;
      pendMask_q  <= pendMask_d;
      pendValid_q <= pendValid_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign NVZflag   = pendValid_q ? mergedFlags : flags_q;
  assign flag_busy = 1'b0;
`else
  assign NVZflag   = flags_q;
  assign flag_busy = pendValid_q;
`endif

endmodule

// File: tb/tb_flag_gen.sv
// Table-driven bench for flag_gen; expectations cover both the default and FLAG_BYPASS_EN builds.
module tb_flag_gen;

`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        stall;
  logic        flush;
  logic [1:0]  op_class;
  logic        alu_sub;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [2:0]  NVZflag;
  logic        flag_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        exValid;
    logic        stall;
    logic        flush;
    logic [1:0]  opClass;
    logic        aluSub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [2:0]  expNvz;
    logic        expBusy;
    logic [2:0]  expNvzBp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  flag_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .stall      (stall),
    .flush      (flush),
    .op_class   (op_class),
    .alu_sub    (alu_sub),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .NVZflag    (NVZflag),
    .flag_busy  (flag_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic ev, logic st, logic fl, logic [1:0] cls,
                              logic sub, logic [15:0] a, logic [15:0] b, logic [15:0] r,
                              logic [2:0] expNvz, logic expBusy, logic [2:0] expNvzBp);
    vec_t v;
    v.name = name; v.exValid = ev; v.stall = st; v.flush = fl; v.opClass = cls;
    v.aluSub = sub; v.a = a; v.b = b; v.r = r;
    v.expNvz = expNvz; v.expBusy = expBusy; v.expNvzBp = expNvzBp;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [2:0] expNvzNb, logic expBusyNb, logic [2:0] expNvzBp);
    logic [2:0] expNvz;
    logic       expBusy;
    expNvz  = BYPASS ? expNvzBp : expNvzNb;
    expBusy = BYPASS ? 1'b0 : expBusyNb;
    checks++;
    if (NVZflag !== expNvz) begin
      errors++;
      $display("[TB] FAIL %s NVZflag got %b expected %b", name, NVZflag, expNvz);
    end
    checks++;
    if (flag_busy !== expBusy) begin
      errors++;
      $display("[TB] FAIL %s flag_busy got %b expected %b", name, flag_busy, expBusy);
    end
  endtask

  // Drive one cycle of inputs just after an edge, then sample just after the next edge.
  task automatic applyStimulus(vec_t v);
    ex_valid   = v.exValid;
    stall      = v.stall;
    flush      = v.flush;
    op_class   = v.opClass;
    alu_sub    = v.aluSub;
    alu_a      = v.a;
    alu_b      = v.b;
    alu_result = v.r;
    @(posedge clk);
    #1;
    checkOutput(v.name, v.expNvz, v.expBusy, v.expNvzBp);
  endtask

  initial begin
    // name, ev, st, fl, cls, sub, a, b, r, expNvz, expBusy, expNvzBypass
    vecs[0]  = mk("add_ovf_capture",   1,0,0,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b000,1,3'b110);
    vecs[1]  = mk("add_ovf_commit",    0,0,0,2'b00,0,16'h0000,16'h0000,16'h0000,3'b110,0,3'b110);
    vecs[2]  = mk("sub_zero_capture",  1,0,0,2'b10,1,16'h0005,16'h0005,16'h0000,3'b110,1,3'b001);
    vecs[3]  = mk("sub_zero_commit",   0,0,0,2'b00,0,16'h0000,16'h0000,16'h0000,3'b001,0,3'b001);
    vecs[4]  = mk("zonly_capture",     1,0,0,2'b01,0,16'h8000,16'h0000,16'h8000,3'b001,1,3'b000);
    vecs[5]  = mk("zonly_commit",      0,0,0,2'b00,0,16'h0000,16'h0000,16'h0000,3'b000,0,3'b000);
    vecs[6]  = mk("b2b_first",         1,0,0,2'b10,1,16'h8000,16'h0001,16'h7FFF,3'b000,1,3'b010);
    vecs[7]  = mk("b2b_second",        1,0,0,2'b10,0,16'h0001,16'h0001,16'h0002,3'b010,1,3'b000);
    vecs[8]  = mk("b2b_drain",         0,0,0,2'b00,0,16'h0000,16'h0000,16'h0000,3'b000,0,3'b000);
    vecs[9]  = mk("flush_no_capture",  1,0,1,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b000,0,3'b000);
    vecs[10] = mk("pre_flush_capture", 1,0,0,2'b10,1,16'h0005,16'h0005,16'h0000,3'b000,1,3'b001);
    vecs[11] = mk("flush_commits",     1,0,1,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b001,0,3'b001);
    vecs[12] = mk("stall_c1",          1,1,0,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b001,0,3'b001);
    vecs[13] = mk("stall_c2",          1,1,0,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b001,0,3'b001);
    vecs[14] = mk("stall_c3",          1,1,0,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b001,0,3'b001);
    vecs[15] = mk("stall_release",     1,0,0,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b001,1,3'b110);
    vecs[16] = mk("stall_commit",      0,0,0,2'b00,0,16'h0000,16'h0000,16'h0000,3'b110,0,3'b110);
    vecs[17] = mk("pre_stall_capture", 1,0,0,2'b10,1,16'h0005,16'h0005,16'h0000,3'b110,1,3'b001);
    vecs[18] = mk("stall_commits",     1,1,0,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b001,0,3'b001);
    vecs[19] = mk("reserved_class",    1,0,0,2'b11,0,16'h7FFF,16'h0001,16'h8000,3'b001,0,3'b001);

    rst_n = 1'b0;
    ex_valid = 1'b0; stall = 1'b0; flush = 1'b0; op_class = 2'b00;
    alu_sub = 1'b0; alu_a = '0; alu_b = '0; alu_result = '0;
    #3;
    checkOutput("reset_state", 3'b000, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset while an update is pending must clear outputs without an edge.
    applyStimulus(mk("pre_reset_capture", 1,0,0,2'b10,0,16'h7FFF,16'h0001,16'h8000,3'b001,1,3'b110));
    ex_valid = 1'b0;
    op_class = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 3'b000, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(mk("reset_discarded", 0,0,0,2'b00,0,16'h0000,16'h0000,16'h0000,3'b000,0,3'b000));
    applyStimulus(mk("reset_idle",      0,0,0,2'b00,0,16'h0000,16'h0000,16'h0000,3'b000,0,3'b000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
